// File: rtl/priority_codec_pkg.sv
// Shared types and helpers for the priority encoder/decoder family.
// Holds the line-state enum and the 2->4 one-hot decode.
package priority_codec_pkg;

    localparam int CODE_W = 2;
    localparam int LINES  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        HOLD   = 2'b10
    } state_t;

    function automatic logic [LINES-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [LINES-1:0] r;
        r = '0;
        unique case (code)
            2'b00: r = 4'b0001;
            2'b01: r = 4'b0010;
            2'b10: r = 4'b0100;
            2'b11: r = 4'b1000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/priority_line_decoder.sv
// Registered 2-to-4 line decoder that stretches each decoded line
// for HOLD_CYCLES cycles after the last accepted code.
module priority_line_decoder
    import priority_codec_pkg::*;
#(
    parameter int HOLD_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Ein,
    input  logic [CODE_W-1:0] Y,
    input  logic              GS,
    output logic [LINES-1:0]  D,
    output logic              Dvalid,
    output logic              Busy,
    output logic              Eout
);

    localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_INIT =
        CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam bit ZERO_HOLD = (HOLD_CYCLES == 0);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [LINES-1:0] d_n;
    logic             dv_n;
    logic             acc;
    logic [LINES-1:0] code;

    assign acc  = Ein && GS;
    assign code = onehot(Y);
    assign Busy = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = D;
        dv_n    = 1'b0;
        if (!Ein) begin
            state_n = IDLE;
            cnt_n   = '0;
            d_n     = '0;
        end else if (acc) begin
            // Strobe only when the visible line actually changes.
            state_n = ACTIVE;
            cnt_n   = '0;
            d_n     = code;
            dv_n    = (code != D);
        end else begin
            unique case (state)
                IDLE: begin
                    d_n = '0;
                end
                ACTIVE: begin
                    if (ZERO_HOLD) begin
                        state_n = IDLE;
                        d_n     = '0;
                    end else begin
                        state_n = HOLD;
                        cnt_n   = HOLD_INIT;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state_n = IDLE;
                        d_n     = '0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    d_n     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            D      <= '0;
            Dvalid <= 1'b0;
            Eout   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            D      <= d_n;
            Dvalid <= dv_n;
            Eout   <= Ein && !GS;
        end
    end

endmodule

// File: tb/tb_priority_line_decoder.sv
// Directed bench for priority_line_decoder (HOLD_CYCLES=3 and 0).
// Expected values are hand-computed per edge.
module tb_priority_line_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       Ein;
    logic [1:0] Y;
    logic       GS;

    logic [3:0] D, D0;
    logic       Dvalid, Dvalid0;
    logic       Busy, Busy0;
    logic       Eout, Eout0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    priority_line_decoder #(.HOLD_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .Ein(Ein), .Y(Y), .GS(GS),
        .D(D), .Dvalid(Dvalid), .Busy(Busy), .Eout(Eout)
    );

    priority_line_decoder #(.HOLD_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .Ein(Ein), .Y(Y), .GS(GS),
        .D(D0), .Dvalid(Dvalid0), .Busy(Busy0), .Eout(Eout0)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic g, input logic [1:0] y);
        Ein = e;
        GS  = g;
        Y   = y;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'($urandom), 1'($urandom), 2'($urandom));
        step();
        drive(1'b1, 1'b1, 2'($urandom));
        step();
        check("rst_D", D, 4'b0000);
        check("rst_Dvalid", Dvalid, 1'b0);
        check("rst_Busy", Busy, 1'b0);
        check("rst_Eout", Eout, 1'b0);

        rst = 1'b0;
        drive(1'b1, 1'b1, 2'b10);
        step();
        check("dec10_D", D, 4'b0100);
        check("dec10_Dvalid", Dvalid, 1'b1);
        check("dec10_Busy", Busy, 1'b1);
        check("dec10_Eout", Eout, 1'b0);
        drive(1'b1, 1'b0, 2'b10);
        step();
        check("dec10_dv_once", Dvalid, 1'b0);
        check("dec10_hold_D", D, 4'b0100);
        check("eout_gs0", Eout, 1'b1);
        step();
        step();
        check("dec10_k3_D", D, 4'b0100);
        step();
        check("dec10_clr_D", D, 4'b0000);
        check("dec10_clr_Busy", Busy, 1'b0);

        // Hold expiry on Y=01
        drive(1'b1, 1'b1, 2'b01);
        step();
        check("exp_k_D", D, 4'b0010);
        check("exp_k_Dvalid", Dvalid, 1'b1);
        drive(1'b1, 1'b0, 2'b01);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("exp_k%0d_D", i), D, 4'b0010);
            check($sformatf("exp_k%0d_Busy", i), Busy, 1'b1);
            check($sformatf("exp_k%0d_Dvalid", i), Dvalid, 1'b0);
        end
        step();
        check("exp_k4_D", D, 4'b0000);
        check("exp_k4_Busy", Busy, 1'b0);
        check("exp_k4_Dvalid", Dvalid, 1'b0);

        // Back-to-back code change, then re-accept during hold
        drive(1'b1, 1'b1, 2'b00);
        step();
        check("chg00_D", D, 4'b0001);
        check("chg00_Dvalid", Dvalid, 1'b1);
        drive(1'b1, 1'b1, 2'b11);
        step();
        check("chg11_D", D, 4'b1000);
        check("chg11_Dvalid", Dvalid, 1'b1);
        drive(1'b1, 1'b0, 2'b11);
        step();
        step();
        drive(1'b1, 1'b1, 2'b11);
        step();
        check("reacc_D", D, 4'b1000);
        check("reacc_Dvalid", Dvalid, 1'b0);
        drive(1'b1, 1'b0, 2'b00);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("reacc_k%0d_D", i), D, 4'b1000);
        end
        step();
        check("reacc_k4_D", D, 4'b0000);

        // Flush mid-hold (cnt=1), GS high must not win
        drive(1'b1, 1'b1, 2'b10);
        step();
        drive(1'b1, 1'b0, 2'b10);
        step();
        step();
        check("fl_pre_D", D, 4'b0100);
        drive(1'b0, 1'b1, 2'b01);
        step();
        check("fl_D", D, 4'b0000);
        check("fl_Busy", Busy, 1'b0);
        check("fl_Dvalid", Dvalid, 1'b0);
        check("fl_Eout", Eout, 1'b0);
        drive(1'b0, 1'b0, 2'b01);
        step();
        check("fl_Eout2", Eout, 1'b0);
        drive(1'b1, 1'b0, 2'b01);
        step();
        check("fl_Eout_rise", Eout, 1'b1);
        check("fl_idle_D", D, 4'b0000);

        // Zero-hold instance
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 2'b01);
        step();
        check("z_D", D0, 4'b0010);
        check("z_Dvalid", Dvalid0, 1'b1);
        drive(1'b1, 1'b0, 2'b01);
        step();
        check("z_clr_D", D0, 4'b0000);
        check("z_clr_Busy", Busy0, 1'b0);
        check("z_clr_Dvalid", Dvalid0, 1'b0);

        // Asynchronous reset mid-ACTIVE
        drive(1'b1, 1'b1, 2'b11);
        step();
        check("ar_pre_D", D, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        check("ar_D", D, 4'b0000);
        check("ar_Busy", Busy, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b1, 2'b00);
        step();
        check("ar_post_D", D, 4'b0001);
        check("ar_post_Dvalid", Dvalid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_line_decoder.md
Name: priority_line_decoder

Overview:
- Registered 2-to-4 line decoder with hold/stretch timing; receive-side counterpart of the team's 4-input priority encoder (Y, GS, enable-in/enable-out).
- Takes a priority code plus group-select and drives a one-hot line vector.
- Each decoded line stays asserted for a programmable number of cycles after the last valid code, so short encoder requests become stable outputs.
- Provides a change strobe, a busy flag and a cascade enable-out for chaining.

Parameters:
- HOLD_CYCLES, 3, extra cycles D stays asserted after the last accepted code (0 allowed).
- CW, $clog2(HOLD_CYCLES+1) (min 1), hold-counter width. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Ein  in  1  enable in. Low = synchronous flush.
- Y  in  2  priority code from encoder.
- GS  in  1  group select; code valid when high.
- D  out  4  one-hot decoded lines, registered.
- Dvalid  out  1  one-cycle strobe when D takes a new nonzero value.
- Busy  out  1  high when state != IDLE.
- Eout  out  1  registered cascade enable-out: Ein && !GS sampled last edge.

Behaviour:
- Single clock is clk. Reset rst is asynchronous and active-high.
- Reset values: D=0, Dvalid=0, Busy=0, Eout=0, state=IDLE, cnt=0. Reset mid-hold clears immediately. First edge after release behaves as from IDLE.
- All inputs are sampled at the rising edge of clk.
- accept = Ein && GS.
- onehot(Y): 00->0001, 01->0010, 10->0100, 11->1000.
- Latency: D reflects an accepted code at the same edge it is sampled, i.e. one cycle after the input is presented.
- States:
  - IDLE: D=0. On accept -> ACTIVE, D<=onehot(Y), Dvalid=1.
  - ACTIVE: accept with same Y -> stay, Dvalid=0. Accept with different Y -> D<=new onehot, Dvalid=1, stay. No accept with Ein=1 -> if HOLD_CYCLES==0 go to IDLE with D<=0; else go to HOLD with cnt<=HOLD_CYCLES-1 and D held.
  - HOLD: accept -> ACTIVE. Dvalid=1 only if onehot(Y) differs from current D; D<=onehot(Y). No accept, cnt==0 -> IDLE, D<=0. No accept, cnt!=0 -> cnt<=cnt-1, D held.
- Timing rule: if the last accept is at edge k, D is nonzero after edges k..k+HOLD_CYCLES and 0 after edge k+HOLD_CYCLES+1.
- Ein=0 at any edge, in any state: D<=0, cnt<=0, state<=IDLE, Dvalid=0. Flush overrides GS.
- Dvalid never asserts when D goes to 0. It asserts for exactly one cycle per new nonzero value, including back-to-back code changes on consecutive edges.
- Eout is updated every edge independent of state.
- D is always zero or exactly one-hot; no other value is legal.
- cnt never underflows; it saturates at 0 when leaving HOLD.

Decomposition:
- Shared package priority_codec_pkg:
  - state enum {IDLE, ACTIVE, HOLD}, 2-bit encoding.
  - onehot decode function (2->4), shared with future encoder/decoder variants.
  - code-width constant CODE_W=2 and line-count constant LINES=4.
- No sub-module. Counter and FSM fit in one module.

Test Plan (HOLD_CYCLES=3):
- Reset and basic decode:
  - rst=1 with random inputs -> D=0, Dvalid=0, Busy=0, Eout=0.
  - Release, then Ein=1, GS=1, Y=10 for one cycle -> next edge D=0100, Dvalid=1 for one cycle, Busy=1.
- Hold expiry: single accept of Y=01 at edge k, then GS=0 -> D=0010 after edges k..k+3, D=0 after edge k+4, Busy drops with it. No Dvalid on clear.
- Code change and re-accept:
  - Y=00 then Y=11 on consecutive accepted edges -> D 0001 then 1000, Dvalid high on both edges.
  - Re-accept Y=11 during HOLD -> D stays 1000, Dvalid=0, hold restarts.
- Flush: hold in progress (D=0100, cnt=1), drive Ein=0 -> next edge D=0, Busy=0. Eout=0 while Ein=0. Ein=1, GS=0 -> Eout=1 one edge later.
- Zero hold and async reset:
  - Rebuild with HOLD_CYCLES=0, accept Y=01 for one cycle -> D=0010 for exactly one cycle, then 0.
  - Assert rst asynchronously mid-ACTIVE -> D=0 immediately, without waiting for a clock edge.
